// File: rtl/alu_arbiter.sv
// Round-robin front end that shares one ALU between two requesters and returns tagged responses.
// Optional statistics counters are built when ALU_ARB_STATS_EN is defined.
module alu_arbiter #(
    parameter int unsigned BITS    = 16,
    parameter int unsigned ALU_LAT = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [BITS-1:0] req0_a,
    input  logic [BITS-1:0] req0_b,
    input  logic [2:0]      req0_op,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [BITS-1:0] req1_a,
    input  logic [BITS-1:0] req1_b,
    input  logic [2:0]      req1_op,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic            resp_id,
    output logic [BITS-1:0] resp_data,
    output logic            resp_err,
    output logic [BITS-1:0] alu_a,
    output logic [BITS-1:0] alu_b,
    output logic [2:0]      alu_op,
    output logic            alu_rst,
    input  logic [BITS-1:0] alu_out,
    input  logic            alu_status,
    output logic            busy,
    output logic [15:0]     op_count,
    output logic [15:0]     err_count
);

    localparam int unsigned CW = (ALU_LAT < 1) ? 1 : $clog2(ALU_LAT + 1);

    typedef enum logic [1:0] {IDLE, EXEC, RESP, RECOVER} state_t;

    state_t          state_q;
    logic            last_grant_q;
    logic [CW-1:0]   cnt_q;
    logic [BITS-1:0] alu_a_q, alu_b_q, resp_data_q;
    logic [2:0]      alu_op_q;
    logic            resp_valid_q, resp_id_q, resp_err_q, alu_rst_q;

    logic grant_id_d;
    logic accept_d;
    logic err_resp_d;

    // When both request, the side that did not win last time gets the grant.
    always_comb begin
        grant_id_d = (req0_valid & req1_valid) ? ~last_grant_q : req1_valid;
    end

    // Ready is gated by rst so nothing looks accepted while reset is held.
    assign req0_ready = rst & (state_q == IDLE) & req0_valid & ~grant_id_d;
    assign req1_ready = rst & (state_q == IDLE) & req1_valid &  grant_id_d;
    assign accept_d   = req0_ready | req1_ready;
    assign err_resp_d = (state_q == EXEC) && (cnt_q == CW'(ALU_LAT)) && alu_status;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= '0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= 1'b0;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b0;
            alu_rst_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept_d) begin
                        alu_a_q      <= grant_id_d ? req1_a  : req0_a;
                        alu_b_q      <= grant_id_d ? req1_b  : req0_b;
                        alu_op_q     <= grant_id_d ? req1_op : req0_op;
                        resp_id_q    <= grant_id_d;
                        last_grant_q <= grant_id_d;
                        cnt_q        <= '0;
                        state_q      <= EXEC;
                    end
                end
                EXEC: begin
                    if (cnt_q == CW'(ALU_LAT)) begin
                        resp_err_q   <= alu_status;
                        resp_data_q  <= alu_status ? '0 : alu_out;
                        resp_valid_q <= 1'b1;
                        state_q      <= RESP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        if (resp_err_q) begin
                            alu_rst_q <= 1'b1;
                            state_q   <= RECOVER;
                        end else begin
                            state_q   <= IDLE;
                        end
                    end
                end
                RECOVER: begin
                    alu_rst_q <= 1'b0;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_op     = alu_op_q;
    assign resp_valid = resp_valid_q;
    assign resp_id    = resp_id_q;
    assign resp_data  = resp_data_q;
    assign resp_err   = resp_err_q;
    assign alu_rst    = ~rst | alu_rst_q;
    assign busy       = (state_q != IDLE);

`ifdef ALU_ARB_STATS_EN
    logic [15:0] op_cnt_q, err_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_cnt_q  <= '0;
            err_cnt_q <= '0;
        end else begin
            if (accept_d && (op_cnt_q != '1))
                op_cnt_q <= op_cnt_q + 16'd1;
            if (err_resp_d && (err_cnt_q != '1))
                err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign op_count  = op_cnt_q;
    assign err_count = err_cnt_q;
`else
    logic unused_err_resp;
    assign unused_err_resp = err_resp_d;
    assign op_count  = '0;
    assign err_count = '0;
`endif

endmodule
